mmio_responder: RTL and testbench

Memory-mapped I/O responder on the processor's data-memory port. Sits between the processor's dmem interface and the dmem syncram, claims the top 16 words of the 12-bit address space for a button/LED/timer register bank, and passes all other accesses through to dmem. Read-data timing is identical to the syncram clocked on ~clock, so the processor needs no change.

---
 rtl/mmio_responder_pkg.sv | 23 ++
 rtl/mmio_responder_if.sv | 13 +
 rtl/mmio_responder_btn_debounce.sv | 51 +++++
 rtl/mmio_responder.sv | 128 ++++++++++++
 tb/tb_mmio_responder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: address map, widths and the hit decode.
package mmio_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LED_W  = 16;
  localparam int unsigned CNT_W  = 8;

  localparam logic [7:0] MMIO_BASE = 8'hFF;

  localparam logic [3:0] OFF_BTN_STATUS  = 4'h0;
  localparam logic [3:0] OFF_BTN_LEVEL   = 4'h1;
  localparam logic [3:0] OFF_BTN_COUNT   = 4'h2;
  localparam logic [3:0] OFF_LED         = 4'h3;
  localparam logic [3:0] OFF_TIMER_COUNT = 4'h4;
  localparam logic [3:0] OFF_TIMER_CMP   = 4'h5;
  localparam logic [3:0] OFF_TIMER_FLAG  = 4'h6;

  function automatic logic is_mmio(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:4] == MMIO_BASE;
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Word-addressed data-memory bus: master drives address/data/wren, slave returns q.
interface mmio_bus_if;
  import mmio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q;

  modport master (output address, output data, output wren, input q);
  modport slave  (input address, input data, input wren, output q);

endinterface

// File: rtl/mmio_responder_btn_debounce.sv
// One button: 2-flop synchronizer, debounce counter, and a rising-edge pulse on the
// same falling edge that the debounced level goes high.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_c_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only advances while the synchronized input disagrees with the level.
  always_comb begin
    level_d  = level_q;
    cnt_d    = '0;
    rise_c_o = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d  = sync2_q;
        rise_c_o = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/mmio_responder.sv
// Button/LED/timer register bank in the top 16 words of dmem space, clocked on ~clock.
// Define MMIO_TIMER_EN to build the timer counter/compare/flag registers.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned NUM_BTN         = 4
) (
  input  logic               clock,
  input  logic               reset,
  mmio_bus_if.slave          cpu,
  mmio_bus_if.master         mem,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [LED_W-1:0]   led_out,
  output logic               timer_flag
);

  logic       hit_c;
  logic [3:0] off_c;
  logic       wr_c;

  assign hit_c = is_mmio(cpu.address);
  assign off_c = cpu.address[3:0];
  assign wr_c  = cpu.wren & hit_c;

  assign mem.address = cpu.address;
  assign mem.data    = cpu.data;
  assign mem.wren    = cpu.wren & ~hit_c;

  logic [NUM_BTN-1:0] level_c, rise_c;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock    (clock),
      .reset    (reset),
      .btn_i    (btn_in[i]),
      .level_o  (level_c[i]),
      .rise_c_o (rise_c[i])
    );
  end

  logic [NUM_BTN-1:0]            status_q, status_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0]              led_q, led_d;
  logic                          rd_hit_q;
  logic [DATA_W-1:0]             rd_val_q, rd_val_d;

  // Press tracking: a new press beats w1c; a count clear beats a new press.
  always_comb begin
    status_d = status_q;
    if (wr_c && off_c == OFF_BTN_STATUS) status_d = status_q & ~cpu.data[NUM_BTN-1:0];
    status_d = status_d | rise_c;
    for (int i = 0; i < NUM_BTN; i++) cnt_d[i] = cnt_q[i] + CNT_W'(rise_c[i]);
    if (wr_c && off_c == OFF_BTN_COUNT) cnt_d = '0;
    led_d = led_q;
    if (wr_c && off_c == OFF_LED) led_d = cpu.data[LED_W-1:0];
  end

`ifdef MMIO_TIMER_EN
  logic [DATA_W-1:0] tmr_q, tmr_d, tmr_inc_c, cmp_q, cmp_d;
  logic              flag_q, flag_d;

  // A load holds the loaded value for that edge and never raises the flag.
  always_comb begin
    tmr_inc_c = tmr_q + DATA_W'(1);
    tmr_d     = tmr_inc_c;
    cmp_d     = cmp_q;
    flag_d    = flag_q;
    if (wr_c && off_c == OFF_TIMER_CMP) cmp_d = cpu.data;
    if (wr_c && off_c == OFF_TIMER_FLAG && cpu.data[0]) flag_d = 1'b0;
    if (wr_c && off_c == OFF_TIMER_COUNT) tmr_d = cpu.data;
    else if (tmr_inc_c == cmp_q) flag_d = 1'b1;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      tmr_q  <= '0;
      cmp_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      cmp_q  <= cmp_d;
      flag_q <= flag_d;
    end
  end

  assign timer_flag = flag_q;
`else
  assign timer_flag = 1'b0;
`endif

  // Read mux samples pre-write register values.
  always_comb begin
    rd_val_d = '0;
    case (off_c)
      OFF_BTN_STATUS:  rd_val_d[NUM_BTN-1:0]       = status_q;
      OFF_BTN_LEVEL:   rd_val_d[NUM_BTN-1:0]       = level_c;
      OFF_BTN_COUNT:   rd_val_d[CNT_W*NUM_BTN-1:0] = cnt_q;
      OFF_LED:         rd_val_d[LED_W-1:0]         = led_q;
`ifdef MMIO_TIMER_EN
      OFF_TIMER_COUNT: rd_val_d                    = tmr_q;
      OFF_TIMER_CMP:   rd_val_d                    = cmp_q;
      OFF_TIMER_FLAG:  rd_val_d[0]                 = flag_q;
`endif
      default:         rd_val_d                    = '0;
    endcase
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      status_q <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      rd_hit_q <= 1'b0;
      rd_val_q <= '0;
    end else begin
      status_q <= status_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      rd_hit_q <= hit_c;
      rd_val_q <= rd_val_d;
    end
  end

  assign cpu.q   = rd_hit_q ? rd_val_q : mem.q;
  assign led_out = led_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with a falling-edge syncram model behind it.
// Covers both builds; timer checks follow MMIO_TIMER_EN.
module tb_mmio_responder;
  import mmio_pkg::*;

  localparam int unsigned NB = 4;

  logic          clock = 1'b1;
  logic          reset;
  logic [NB-1:0] btn_in;
  logic [15:0]   led_out;
  logic          timer_flag;

  mmio_bus_if cpu_if ();
  mmio_bus_if mem_if ();

  mmio_responder #(.DEBOUNCE_CYCLES(4), .NUM_BTN(NB)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu        (cpu_if),
    .mem        (mem_if),
    .btn_in     (btn_in),
    .led_out    (led_out),
    .timer_flag (timer_flag)
  );

  always #5 clock = ~clock;

  // dmem syncram model, clocked on the falling edge like the real one
  logic [31:0] ram [0:4095];
  logic [31:0] ram_q;
  logic        ff3_wr = 1'b0;
  always @(negedge clock) begin
    if (mem_if.wren) ram[mem_if.address] <= mem_if.data;
    if (mem_if.wren && mem_if.address == 12'hFF3) ff3_wr <= 1'b1;
    ram_q <= ram[mem_if.address];
  end
  assign mem_if.q = ram_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    cpu_if.address = a;
    cpu_if.wren    = 1'b0;
    step(1);
    chk(tag, cpu_if.q, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic exp_mw, input string tag);
    cpu_if.address = a;
    cpu_if.data    = d;
    cpu_if.wren    = 1'b1;
    #1;
    chk(tag, 32'(mem_if.wren), 32'(exp_mw));
    step(1);
    cpu_if.wren    = 1'b0;
  endtask

  task automatic press0();
    btn_in[0] = 1'b1;
    step(7);
    btn_in[0] = 1'b0;
    step(7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    btn_in         = '0;
    cpu_if.address = '0;
    cpu_if.data    = '0;
    cpu_if.wren    = 1'b0;
    step(2);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_flag", 32'(timer_flag), 32'h0);
    reset = 1'b0;

    rd(12'hFF0, 32'h0, "rst_status");
    rd(12'hFF1, 32'h0, "rst_level");
    rd(12'hFF2, 32'h0, "rst_count");
    rd(12'hFF3, 32'h0, "rst_led_rd");
    rd(12'hFF5, 32'h0, "rst_cmp");
    rd(12'hFF6, 32'h0, "rst_tflag");
    rd(12'hFFA, 32'h0, "unused_rd");

    // pass-through to dmem
    wr(12'h010, 32'h1234, 1'b1, "dmem_wren");
    rd(12'h010, 32'h1234, "dmem_rd");

    // LED register, never reaches dmem
    wr(12'hFF3, 32'hABCDBEEF, 1'b0, "led_wren");
    chk("led_out", 32'(led_out), 32'h0000BEEF);
    rd(12'hFF3, 32'h0000BEEF, "led_rd");
    wr(12'hFF3, 32'h00001111, 1'b0, "led_wren2");
    chk("led_rd_during_wr", cpu_if.q, 32'h0000BEEF);
    chk("led_out2", 32'(led_out), 32'h00001111);
    chk("dmem_ff3_untouched", 32'(ff3_wr), 32'h0);

    // glitch on button 1 is filtered
    btn_in[1] = 1'b1;
    step(3);
    btn_in[1] = 1'b0;
    step(8);
    rd(12'hFF1, 32'h0, "glitch_level");
    rd(12'hFF0, 32'h0, "glitch_status");

    // real press on button 1
    btn_in[1] = 1'b1;
    step(10);
    rd(12'hFF1, 32'h2, "press_level");
    rd(12'hFF0, 32'h2, "press_status");
    rd(12'hFF2, 32'h00000100, "press_count");
    btn_in[1] = 1'b0;
    step(8);
    rd(12'hFF1, 32'h0, "release_level");
    wr(12'hFF0, 32'h2, 1'b0, "w1c_wren");
    rd(12'hFF0, 32'h0, "w1c_status");

    // 256 presses on button 0 wrap its count byte
    for (int p = 0; p < 255; p++) press0();
    rd(12'hFF2, 32'h000001FF, "count_255");
    press0();
    rd(12'hFF2, 32'h00000100, "count_wrap");
    rd(12'hFF0, 32'h1, "status_b0");

    // press coincident with w1c: set wins
    btn_in[0] = 1'b1;
    step(5);
    wr(12'hFF0, 32'h1, 1'b0, "w1c_race_wren");
    rd(12'hFF0, 32'h1, "set_beats_w1c");
    wr(12'hFF0, 32'h1, 1'b0, "w1c2_wren");
    rd(12'hFF0, 32'h0, "w1c_plain");

    // press coincident with count clear: clear wins
    btn_in[0] = 1'b0;
    step(7);
    btn_in[0] = 1'b1;
    step(5);
    wr(12'hFF2, 32'h0, 1'b0, "clr_race_wren");
    rd(12'hFF2, 32'h0, "clear_beats_inc");
    rd(12'hFF0, 32'h1, "status_after_clr");
    btn_in[0] = 1'b0;
    step(7);

`ifdef MMIO_TIMER_EN
    wr(12'hFF5, 32'h0, 1'b0, "cmp_wren");
    wr(12'hFF4, 32'hFFFFFFFE, 1'b0, "cnt_wren");
    chk("tflag_load", 32'(timer_flag), 32'h0);
    step(1);
    chk("tflag_ffff", 32'(timer_flag), 32'h0);
    step(1);
    chk("tflag_wrap", 32'(timer_flag), 32'h1);
    rd(12'hFF6, 32'h1, "tflag_rd");
    rd(12'hFF4, 32'h1, "tcount_rd");
    wr(12'hFF6, 32'h1, 1'b0, "tflag_w1c_wren");
    chk("tflag_w1c", 32'(timer_flag), 32'h0);
    wr(12'hFF5, 32'h100, 1'b0, "cmp2_wren");
    wr(12'hFF4, 32'h100, 1'b0, "cnt2_wren");
    chk("tflag_load_eq", 32'(timer_flag), 32'h0);
    step(1);
    chk("tflag_after_load", 32'(timer_flag), 32'h0);
    rd(12'hFF5, 32'h100, "cmp_rd");
`else
    wr(12'hFF4, 32'h5, 1'b0, "tcount_wren");
    rd(12'hFF4, 32'h0, "notimer_count");
    wr(12'hFF5, 32'h7, 1'b0, "tcmp_wren");
    rd(12'hFF5, 32'h0, "notimer_cmp");
    chk("notimer_flag", 32'(timer_flag), 32'h0);
`endif

    // asynchronous reset mid-press and with LED set
    btn_in[2] = 1'b1;
    step(3);
    reset = 1'b1;
    #1;
    chk("midreset_led", 32'(led_out), 32'h0);
    btn_in[2] = 1'b0;
    step(1);
    reset = 1'b0;
    step(8);
    rd(12'hFF1, 32'h0, "midreset_level");
    rd(12'hFF0, 32'h0, "midreset_status");
    rd(12'hFF2, 32'h0, "midreset_count");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
